// File: rtl/sipo_deserializer_if.sv
// Bit-stream and word handshake bundle for sipo_deserializer.
// A transfer happens on a rising edge where val and rdy are both high; val must not wait on rdy.
interface sipo_deserializer_if #(
  parameter int NBITS = 8
);
  logic             in_val;
  logic             in_rdy;
  logic             in_bit;
  logic             out_val;
  logic             out_rdy;
  logic [NBITS-1:0] out_data;
  logic             out_err;

  modport master (
    output in_val, in_bit, out_rdy,
    input  in_rdy, out_val, out_data, out_err
  );

  modport slave (
    input  in_val, in_bit, out_rdy,
    output in_rdy, out_val, out_data, out_err
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: LSB-first words of NBITS under val/rdy handshakes.
// Define SIPO_DESERIALIZER_PARITY_EN to append an even-parity bit to each word and flag errors on out_err.
module sipo_deserializer #(
  parameter int NBITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  sipo_deserializer_if.slave  bus,
  output logic                o_dbg_state,
  output logic [5:0]          o_dbg_cnt
);

`ifdef SIPO_DESERIALIZER_PARITY_EN
  localparam int WLEN = NBITS + 1;
`else
  localparam int WLEN = NBITS;
`endif
  localparam int CW = $clog2(WLEN + 1);
  localparam logic [CW-1:0] LAST = CW'(WLEN - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WLEN-1:0]  r_sr;
  logic [WLEN-1:0]  w_sr_shift;
  logic [NBITS-1:0] r_data;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_load;
  logic             w_in_rdy;
  logic             w_out_val;
  logic             w_in_fire;
  logic             w_out_fire;

  // in_rdy depends only on state and out_rdy, so a full word can drain and refill on one edge.
  always_comb begin
    w_out_val  = (r_state == FULL);
    w_in_rdy   = (r_state == FILL) | bus.out_rdy;
    w_in_fire  = bus.in_val & w_in_rdy;
    w_out_fire = w_out_val & bus.out_rdy;
    w_sr_shift = {bus.in_bit, r_sr[WLEN-1:1]};
  end

`ifdef SIPO_DESERIALIZER_PARITY_EN
  assign w_err_nxt = ^w_sr_shift;
`else
  assign w_err_nxt = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    case (r_state)
      FILL: begin
        if (w_in_fire) begin
          if (r_cnt == LAST) begin
            w_state_nxt = FULL;
            w_cnt_nxt   = '0;
            w_load      = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      FULL: begin
        if (w_out_fire) begin
          w_state_nxt = FILL;
          w_cnt_nxt   = w_in_fire ? CW'(1) : '0;
        end
      end
      default: begin
        w_state_nxt = FILL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= FILL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Stale bits of a drained word need no clearing: the next WLEN shifts push them out.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sr   <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_sr <= w_sr_shift;
      end
      if (w_load) begin
        r_data <= w_sr_shift[NBITS-1:0];
        r_err  <= w_err_nxt;
      end
    end
  end

  assign bus.in_rdy   = w_in_rdy;
  assign bus.out_val  = w_out_val;
  assign bus.out_data = r_data;
  assign bus.out_err  = r_err;
  assign o_dbg_state  = r_state;
  assign o_dbg_cnt    = 6'(r_cnt);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench for sipo_deserializer (NBITS = 8).
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_sipo_deserializer;
  localparam int NBITS = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       dbg_state;
  logic [5:0] dbg_cnt;

  sipo_deserializer_if #(.NBITS(NBITS)) bus ();

  sipo_deserializer #(.NBITS(NBITS)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_cnt   (dbg_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int fire_cyc[$];
  logic [NBITS:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic send_bit(input logic b);
    int n;
    bus.in_val = 1'b1;
    bus.in_bit = b;
    n = 0;
    while (!bus.in_rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 50) check("in_rdy_timeout", bus.in_rdy, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  // scoreboard: every accepted word must match the head of exp_q as {out_err, out_data}
  always @(negedge clk) begin
    if (reset_n && bus.out_val && bus.out_rdy) begin
      check("exp_q_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("word", {bus.out_err, bus.out_data}, exp_q.pop_front());
      fire_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_val  = 1'b0;
    bus.in_bit  = 1'b0;
    bus.out_rdy = 1'b0;
    reset_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_out_val", bus.out_val, 0);
    check("rst_out_data", bus.out_data, 8'h00);
    check("rst_in_rdy", bus.in_rdy, 1);
    check("rst_out_err", bus.out_err, 0);
    check("rst_state", dbg_state, 0);
    check("rst_cnt", dbg_cnt, 0);
    @(posedge clk); #1;

`ifndef SIPO_DESERIALIZER_PARITY_EN
    // single word 1,0,1,1,0,0,1,0 -> 0x4D, then backpressure with next bit pending
    bus.out_rdy = 1'b0;
    send_bits(32'h4D, 8);
    bus.in_bit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_val", bus.out_val, 1);
      check("bp_out_data", bus.out_data, 8'h4D);
      check("bp_in_rdy", bus.in_rdy, 0);
      check("bp_cnt", dbg_cnt, 0);
      @(posedge clk); #1;
    end
    exp_q.push_back({1'b0, 8'h4D});
    bus.out_rdy = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("drain_cnt", dbg_cnt, 1);
    check("drain_out_val", bus.out_val, 0);
    check("drain_state", dbg_state, 0);
    check("drain_fires", fire_cyc.size(), 1);

    // back-to-back 0xFF (first bit already taken) then 0x01
    exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b0, 8'h01});
    send_bits(32'h7F, 7);
    send_bits(32'h01, 8);
    bus.in_val = 1'b0;
    @(negedge clk);
    check("b2b_out_val", bus.out_val, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_out_val_low", bus.out_val, 0);
    check("b2b_fires", fire_cyc.size(), 3);
    if (fire_cyc.size() == 3) begin
      check("b2b_gap1", fire_cyc[1] - fire_cyc[0], 8);
      check("b2b_gap2", fire_cyc[2] - fire_cyc[1], 8);
    end
    check("b2b_q_empty", exp_q.size(), 0);

    // reset mid-word, then 0xA5
    @(posedge clk); #1;
    send_bits(32'hF, 4);
    bus.in_val = 1'b0;
    @(negedge clk);
    check("mid_cnt", dbg_cnt, 4);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rst_cnt", dbg_cnt, 0);
    check("mid_rst_data", bus.out_data, 8'h00);
    check("mid_rst_val", bus.out_val, 0);
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 8'hA5});
    send_bits(32'hA5, 8);
    bus.in_val = 1'b0;
    @(negedge clk);
    check("a5_out_val", bus.out_val, 1);
    check("a5_out_data", bus.out_data, 8'hA5);
    @(posedge clk); #1;
    @(negedge clk);
    check("a5_q_empty", exp_q.size(), 0);
    check("a5_fires", fire_cyc.size(), 4);
`else
    // parity: 0x03 with correct parity 0, then 0x03 with bad parity 1
    bus.out_rdy = 1'b1;
    exp_q.push_back({1'b0, 8'h03});
    send_bits(32'h003, 9);
    bus.in_val = 1'b0;
    @(negedge clk);
    check("par0_out_err", bus.out_err, 0);
    check("par0_out_data", bus.out_data, 8'h03);
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 8'h03});
    send_bits(32'h103, 9);
    bus.in_val = 1'b0;
    @(negedge clk);
    check("par1_out_err", bus.out_err, 1);
    check("par1_out_data", bus.out_data, 8'h03);
    @(posedge clk); #1;
    @(negedge clk);
    check("par_q_empty", exp_q.size(), 0);
    check("par_fires", fire_cyc.size(), 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in/parallel-out deserializer that sits directly downstream of the D flip-flop stage and consumes its one-bit `q` stream. It accepts one bit per cycle under a val/rdy handshake, assembles `NBITS`-wide words LSB-first, and presents each completed word on a val/rdy output port. Back-to-back words run at full rate: a word drains and the first bit of the next word is accepted on the same edge.

## Interface
- `NBITS`, default 8, data word width; legal range 2..32.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_val`  in  1  upstream bit valid.
- `in_rdy`  out  1  block can accept a bit this cycle.
- `in_bit`  in  1  serial data bit, normally the flip-flop's `q`.
- `out_val`  out  1  `out_data` holds a complete word.
- `out_rdy`  in  1  downstream accepts the word.
- `out_data`  out  NBITS  assembled word; bit 0 is the first bit received.
- `out_err`  out  1  parity error flag for the current word; tied 0 when parity is compiled out.

## Operation
- Two-state FSM, `FILL` and `FULL`, plus a bit counter `cnt` of width clog2(WLEN+1).
  - `WLEN = NBITS`, or `NBITS+1` when parity is enabled.
- Input accept: `in_fire = in_val & in_rdy`.
- Output accept: `out_fire = out_val & out_rdy`.
- `in_rdy = (state == FILL) | out_rdy`. This path is combinational from `out_rdy`; there is no path from `in_val` to `in_rdy`.
- `FILL` state:
  - On `in_fire`, the shift register shifts right with `in_bit` entering at the MSB, and `cnt` increments.
  - On the `in_fire` that makes `cnt == WLEN`: go to `FULL` and clear `cnt` to 0.
- `FULL` state:
  - `out_val = 1`; `out_data` and `out_err` are held stable until `out_fire`.
  - On `out_fire` without `in_fire`: go to `FILL` with `cnt = 0`.
  - On `out_fire` with `in_fire` (same edge): the word drains, `in_bit` becomes bit 1 of the next word, the state goes to `FILL`, and `cnt = 1`.
- `in_val` while `FULL` and `out_rdy = 0`: `in_rdy = 0`, nothing is accepted, and upstream holds the bit.
- `in_val` low mid-word: the partial word is retained indefinitely; there is no timeout.
- Reset (any state, including mid-word or `FULL`):
  - state = `FILL`, `cnt = 0`, shift register = 0.
  - Outputs: `out_val = 0`, `out_data = 0`, `out_err = 0`; `in_rdy = 1`.
  - Any partial or pending word is discarded.

## Timing
- Latency: `out_val` rises on the rising edge that accepts the last bit of the word. A word of `WLEN` bits accepted on consecutive edges E1..E_WLEN is valid after E_WLEN.
- Throughput: one bit per cycle sustained, provided `out_rdy` is high in every `FULL` cycle. In that case `out_val` is high for exactly 1 cycle in every `WLEN`.
- `out_data` and `out_err` are registered outputs. `out_val` is decoded from the state register.
- Inputs are sampled only at the rising edge; setup is relative to that edge.

## Configuration
- Macro: `SIPO_DESERIALIZER_PARITY_EN`.
- Defined:
  - Each word is `NBITS` data bits followed by 1 even-parity bit, so `WLEN = NBITS+1`.
  - The parity bit is not placed in `out_data`.
  - `out_err = 1` iff the XOR of the `NBITS` data bits and the parity bit is 1. `out_err` is valid with `out_val`.
- Undefined:
  - `WLEN = NBITS`; there is no parity bit.
  - `out_err` is constantly 0. The port is still present.

## Test plan
All scenarios use `NBITS = 8` with the macro undefined, except where noted.
- Reset:
  - Stimulus: `reset_n = 0` for 2 cycles, then release.
  - Required: `out_val = 0`, `out_data = 0x00`, `in_rdy = 1`, `out_err = 0`.
- Single word:
  - Stimulus: bits 1,0,1,1,0,0,1,0 on consecutive cycles, `out_rdy = 0`.
  - Required: `out_val = 1` after the 8th edge, `out_data = 0x4D`, and `in_rdy = 0` while waiting.
- Backpressure:
  - Stimulus: hold `out_rdy = 0` for 5 cycles with `in_val = 1`, then set `out_rdy = 1`.
  - Required: `out_data` stays 0x4D throughout, and the next word's first bit is accepted on the drain edge (`cnt = 1` afterward).
- Back-to-back:
  - Stimulus: 0xFF then 0x01 streamed continuously with `out_rdy = 1`.
  - Required: `out_val` is a 1-cycle pulse every 8 cycles, with words 0xFF then 0x01 and no dropped bits.
- Reset mid-word:
  - Stimulus: 4 bits accepted, `reset_n = 0` for 1 cycle, then 8 bits of 0xA5.
  - Required: `out_data = 0xA5`.
- Parity (macro defined):
  - Stimulus: data 0x03 + parity 0, then data 0x03 + parity 1.
  - Required: `out_err = 0` for the first word, `out_err = 1` for the second, `out_data = 0x03` for both.
